// File: rtl/hx8357_reader_if.sv
// Bundle between the HX8357 read-side controller and its host/panel environment.
// Host side: start, cmd_in, n_words in; busy, rd_data, rd_valid, done out.
// Panel side: CSx, DCx, WRx, RDx, DATA_out, DATA_oe out; DATA_in from the panel.
// master: the reader controller. slave: the host/panel environment.
interface hx8357_reader_if;
  logic        start;
  logic [15:0] cmd_in;
  logic [7:0]  n_words;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        CSx;
  logic        DCx;
  logic        WRx;
  logic        RDx;
  logic [15:0] DATA_out;
  logic        DATA_oe;
  logic [15:0] DATA_in;

  modport master (
    input  start, cmd_in, n_words, DATA_in,
    output busy, rd_data, rd_valid, done, CSx, DCx, WRx, RDx, DATA_out, DATA_oe
  );

  modport slave (
    output start, cmd_in, n_words, DATA_in,
    input  busy, rd_data, rd_valid, done, CSx, DCx, WRx, RDx, DATA_out, DATA_oe
  );
endinterface

// File: rtl/hx8357_reader.sv
// HX8357 8080-style read-side bus controller.
// Issues one command word with a WRx strobe, releases the bus, then performs
// timed RDx strobes and returns each captured word with a one-cycle rd_valid.
// Ports:
//   clk  - block clock (shared divided clock of the write path)
//   res  - asynchronous active-high reset
//   bus  - hx8357_reader_if.master: host request/response and panel pins
// Parameters: WR_LO/WR_HI command strobe low/high cycles, RD_LO/RD_HI read
// strobe low/high cycles.
// Build option: define HX8357_RD_DUMMY_EN to insert one discarded dummy read
// before the data reads (skipped entirely when n_words is 0).
// All outputs are registered from the next-state decode, so each output
// reflects the state of the cycle it appears in.
module hx8357_reader #(
  parameter int unsigned WR_LO = 1,
  parameter int unsigned WR_HI = 1,
  parameter int unsigned RD_LO = 4,
  parameter int unsigned RD_HI = 2
) (
  input logic             clk,
  input logic             res,
  hx8357_reader_if.master bus
);

`ifdef HX8357_RD_DUMMY_EN
  localparam logic DummyEn = 1'b1;
`else
  localparam logic DummyEn = 1'b0;
`endif

  // Phase timers count down from length-1 to 0.
  localparam logic [7:0] WrLoM1 = 8'(WR_LO - 1);
  localparam logic [7:0] WrHiM1 = 8'(WR_HI - 1);
  localparam logic [7:0] RdLoM1 = 8'(RD_LO - 1);
  localparam logic [7:0] RdHiM1 = 8'(RD_HI - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StCmdLo, StCmdHi, StTurn, StRdLo, StRdHi, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [8:0]  cnt_q, cnt_d;    // 9 bits: 255 words plus dummy must not wrap
  logic        dummy_q, dummy_d; // current read is the discarded dummy
  logic        tmr_zero;
  logic        accept;
  logic        capture;

  logic        csx_q, dcx_q, wrx_q, rdx_q, oe_q;
  logic [15:0] dout_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q, done_q, busy_q;

  assign tmr_zero = (tmr_q == 8'd0);
  assign accept   = (state_q == StIdle) && bus.start;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_zero ? tmr_q : tmr_q - 8'd1;
    cnt_d   = cnt_q;
    dummy_d = dummy_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSetup;
          cnt_d   = (bus.n_words == 8'd0) ? 9'd0 : {1'b0, bus.n_words} + {8'd0, DummyEn};
          dummy_d = DummyEn;
        end
      end
      StSetup: begin
        state_d = StCmdLo;
        tmr_d   = WrLoM1;
      end
      StCmdLo: begin
        if (tmr_zero) begin
          state_d = StCmdHi;
          tmr_d   = WrHiM1;
        end
      end
      StCmdHi: begin
        if (tmr_zero) state_d = StTurn;
      end
      StTurn: begin
        if (cnt_q == 9'd0) begin
          state_d = StDone;
        end else begin
          state_d = StRdLo;
          tmr_d   = RdLoM1;
        end
      end
      StRdLo: begin
        if (tmr_zero) begin
          state_d = StRdHi;
          tmr_d   = RdHiM1;
          cnt_d   = cnt_q - 9'd1;
          capture = !dummy_q;
          dummy_d = 1'b0;
        end
      end
      StRdHi: begin
        if (tmr_zero) begin
          if (cnt_q != 9'd0) begin
            state_d = StRdLo;
            tmr_d   = RdLoM1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= StIdle;
      tmr_q   <= 8'd0;
      cnt_q   <= 9'd0;
      dummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      dummy_q <= dummy_d;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      csx_q      <= 1'b1;
      dcx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      rdx_q      <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= 16'd0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      csx_q      <= (state_d == StIdle) || (state_d == StDone);
      dcx_q      <= !(state_d inside {StSetup, StCmdLo, StCmdHi});
      wrx_q      <= (state_d != StCmdLo);
      rdx_q      <= (state_d != StRdLo);
      oe_q       <= state_d inside {StSetup, StCmdLo, StCmdHi};
      rd_valid_q <= capture;
      done_q     <= (state_d == StDone);
      busy_q     <= (state_d != StIdle);
      // The command latch doubles as the driven bus value.
      if (accept) dout_q <= bus.cmd_in;
      if (capture) rd_data_q <= bus.DATA_in;
    end
  end

  assign bus.CSx      = csx_q;
  assign bus.DCx      = dcx_q;
  assign bus.WRx      = wrx_q;
  assign bus.RDx      = rdx_q;
  assign bus.DATA_oe  = oe_q;
  assign bus.DATA_out = dout_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_hx8357_reader.sv
// Directed self-checking bench for hx8357_reader (default timing parameters).
// A small panel model returns a fixed word list on each falling RDx edge.
// Expected cycle numbers follow the HX8357_RD_DUMMY_EN build option.
module tb_hx8357_reader;

`ifdef HX8357_RD_DUMMY_EN
  localparam int Dum = 1;
`else
  localparam int Dum = 0;
`endif

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  hx8357_reader_if bus ();

  hx8357_reader dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Panel model: next word on every falling RDx.
  logic [15:0] words [4];
  int          rd_cnt = 0;
  int          base   = 0;

  always @(negedge bus.RDx) begin
    int idx;
    idx = rd_cnt - base;
    bus.DATA_in = (idx >= 0 && idx < 4) ? words[idx[1:0]] : 16'hDEAD;
    rd_cnt = rd_cnt + 1;
  end

  // Per-cycle trace of one transaction, indexed by cycle number after E0.
  logic        csx_t  [81];
  logic        dcx_t  [81];
  logic        wrx_t  [81];
  logic        oe_t   [81];
  logic        busy_t [81];
  logic [15:0] dout_t [81];
  int          v_cyc  [4];
  logic [15:0] v_dat  [4];
  int done_cyc, n_done, n_valid, rdx_lo, wrx_lo, clash, saw_aa;

  task automatic run_txn(input logic [15:0] cmd, input logic [7:0] n, input int pulse_at);
    int k;
    base = rd_cnt;
    done_cyc = -1; n_done = 0; n_valid = 0; rdx_lo = 0; wrx_lo = 0; clash = 0; saw_aa = 0;
    for (int i = 0; i < 4; i++) begin
      v_cyc[i] = -1;
      v_dat[i] = 16'hFFFF;
    end
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd_in  = cmd;
    bus.n_words = n;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (k < 80) begin
      csx_t[k]  = bus.CSx;
      dcx_t[k]  = bus.DCx;
      wrx_t[k]  = bus.WRx;
      oe_t[k]   = bus.DATA_oe;
      busy_t[k] = bus.busy;
      dout_t[k] = bus.DATA_out;
      if (!bus.RDx) rdx_lo++;
      if (!bus.WRx) wrx_lo++;
      if (!bus.RDx && bus.DATA_oe) clash++;
      if (bus.rd_data == 16'h00AA) saw_aa++;
      if (bus.rd_valid) begin
        if (n_valid < 4) begin
          v_cyc[n_valid] = k;
          v_dat[n_valid] = bus.rd_data;
        end
        n_valid++;
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      k++;
      @(negedge clk);
      bus.start = (k == pulse_at);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.cmd_in  = 16'd0;
    bus.n_words = 8'd0;
    if (Dum == 1) begin
      words[0] = 16'h00AA; words[1] = 16'h1234; words[2] = 16'h5678; words[3] = 16'h9ABC;
    end else begin
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_csx", 32'(bus.CSx), 32'd1);
    check("rst_dcx", 32'(bus.DCx), 32'd1);
    check("rst_wrx", 32'(bus.WRx), 32'd1);
    check("rst_rdx", 32'(bus.RDx), 32'd1);
    check("rst_oe", 32'(bus.DATA_oe), 32'd0);
    check("rst_dout", 32'(bus.DATA_out), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    res = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word read of ID.
    run_txn(16'h0004, 8'd2, 0);
    check("t1_csx_c1", 32'(csx_t[1]), 32'd0);
    check("t1_wrx_c2", 32'(wrx_t[2]), 32'd0);
    check("t1_dout_c2", 32'(dout_t[2]), 32'h0004);
    check("t1_dcx_c2", 32'(dcx_t[2]), 32'd0);
    check("t1_oe_c2", 32'(oe_t[2]), 32'd1);
    check("t1_wrx_c3", 32'(wrx_t[3]), 32'd1);
    check("t1_oe_c4", 32'(oe_t[4]), 32'd0);
    check("t1_dcx_c4", 32'(dcx_t[4]), 32'd1);
    check("t1_n_valid", 32'(n_valid), 32'd2);
    check("t1_v0_cyc", 32'(v_cyc[0]), 32'(9 + 6 * Dum));
    check("t1_v0_dat", 32'(v_dat[0]), 32'h1234);
    check("t1_v1_cyc", 32'(v_cyc[1]), 32'(15 + 6 * Dum));
    check("t1_v1_dat", 32'(v_dat[1]), 32'h5678);
    check("t1_no_aa", 32'(saw_aa), 32'd0);
    check("t1_done_cyc", 32'(done_cyc), 32'(17 + 6 * Dum));
    check("t1_csx_after", 32'(csx_t[done_cyc + 1]), 32'd1);
    check("t1_rdx_lo", 32'(rdx_lo), 32'((2 + Dum) * 4));
    check("t1_clash", 32'(clash), 32'd0);

    // Zero-word command.
    run_txn(16'h0029, 8'd0, 0);
    check("t2_wrx_lo", 32'(wrx_lo), 32'd1);
    check("t2_rdx_lo", 32'(rdx_lo), 32'd0);
    check("t2_done_cyc", 32'(done_cyc), 32'd5);
    check("t2_n_valid", 32'(n_valid), 32'd0);
    check("t2_dout_c2", 32'(dout_t[2]), 32'h0029);

    // Start pulsed while busy is ignored.
    run_txn(16'h0009, 8'd1, 6);
    check("t3_n_done", 32'(n_done), 32'd1);
    check("t3_done_cyc", 32'(done_cyc), 32'(11 + 6 * Dum));
    check("t3_busy_after", 32'(busy_t[done_cyc + 2]), 32'd0);
    check("t3_v0_dat", 32'(v_dat[0]), 32'h1234);

    // Reset during the first RD_LO phase aborts at once.
    base = rd_cnt;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd_in  = 16'h002E;
    bus.n_words = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_rdx_pre", 32'(bus.RDx), 32'd0);
    res = 1'b1;
    #1;
    check("t4_rdx", 32'(bus.RDx), 32'd1);
    check("t4_csx", 32'(bus.CSx), 32'd1);
    check("t4_oe", 32'(bus.DATA_oe), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    res = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("t4_no_done", 32'(n_done), 32'd0);
    run_txn(16'h002E, 8'd2, 0);
    check("t4_done_cyc", 32'(done_cyc), 32'(17 + 6 * Dum));
    check("t4_v0_dat", 32'(v_dat[0]), 32'h1234);
    check("t4_v1_dat", 32'(v_dat[1]), 32'h5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
